// File: rtl/uart_rx_os.sv
// UART receiver: recovers DBIT-N-stop frames from an OS-x oversampling tick, flags framing errors and breaks.
// Optional 2-of-3 majority sampling of each bit is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx_os #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned OS      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            break_det
);
    localparam int unsigned SW = 5;
    localparam int unsigned NW = 4;

`ifdef UART_RX_MAJORITY_EN
    // Decisions land on mid+1; reloading s_reg with 1 keeps the bit spacing at OS ticks.
    localparam int unsigned START_END = OS / 2;
    localparam int unsigned DATA_END  = OS;
    localparam int unsigned STOP_MID  = OS;
    localparam int unsigned STOP_END  = (SB_TICK - 1 > OS) ? SB_TICK - 1 : OS;
    localparam int unsigned RELOAD    = 1;
`else
    localparam int unsigned START_END = OS / 2 - 1;
    localparam int unsigned DATA_END  = OS - 1;
    localparam int unsigned STOP_MID  = OS - 1;
    localparam int unsigned STOP_END  = SB_TICK - 1;
    localparam int unsigned RELOAD    = 0;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [SW-1:0]   s_reg;
    logic [NW-1:0]   n_reg;
    logic [DBIT-1:0] b_reg;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_prev;
    logic            stop_q;
    logic            sample_c;
    logic            stop_c;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [SW-1:0] mid_c;
    logic          m0;
    logic          m1;

    always_comb begin
        mid_c = SW'(STOP_MID);
        case (state)
            START:   mid_c = SW'(START_END);
            DATA:    mid_c = SW'(DATA_END);
            default: mid_c = SW'(STOP_MID);
        endcase
    end

    // Capture the two samples preceding the decision tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0 <= 1'b1;
            m1 <= 1'b1;
        end else if (s_tick && state != IDLE) begin
            if (s_reg == mid_c - SW'(2)) m0 <= rx_s;
            if (s_reg == mid_c - SW'(1)) m1 <= rx_s;
        end
    end

    assign sample_c = (m0 & m1) | (m0 & rx_s) | (m1 & rx_s);
`else
    assign sample_c = rx_s;
`endif

    // With longer stop periods only the first stop-bit midpoint decides validity.
    assign stop_c = (STOP_END == STOP_MID) ? sample_c : stop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            stop_q       <= 1'b1;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (break_det && rx_s) break_det <= 1'b0;
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        s_reg <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_reg == SW'(START_END)) begin
                            if (!sample_c) begin
                                state <= DATA;
                                s_reg <= SW'(RELOAD);
                                n_reg <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_reg <= s_reg + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_reg == SW'(DATA_END)) begin
                            b_reg <= {sample_c, b_reg[DBIT-1:1]};
                            s_reg <= SW'(RELOAD);
                            if (n_reg == NW'(DBIT - 1)) state <= STOP;
                            else n_reg <= n_reg + NW'(1);
                        end else begin
                            s_reg <= s_reg + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_reg == SW'(STOP_MID)) stop_q <= sample_c;
                        if (s_reg == SW'(STOP_END)) begin
                            dout         <= b_reg;
                            rx_done_tick <= 1'b1;
                            frame_err    <= !stop_c;
                            if (!stop_c && b_reg == '0) break_det <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            s_reg <= s_reg + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receiver: the receive end of the serial link driven by uart_tx.
- Recovers 8N1-style frames from the async rx line using a 16x oversampling tick from mod_m_counter (DVSR = 50M/(16*baud)).
- Outputs each received byte with a one-cycle done strobe, plus framing-error and break flags.
- Sits between the rx pin (via a 2-FF synchronizer) and the rx FIFO in the uart top.

Parameters:
- DBIT, 8, number of data bits per frame, LSB first (5..9 supported).
- SB_TICK, 16, ticks sampled for the stop bit: 16/24/32 for 1/1.5/2 stop bits.
- OS, 16, oversampling ticks per bit; must be even and at least 8.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- s_tick  input  1  oversampling enable, one clk wide, OS pulses per bit period.
- rx  input  1  raw serial line, idle high; not yet synchronized.
- dout  output  DBIT  last received data word.
- rx_done_tick  output  1  one-clk strobe when dout is updated.
- frame_err  output  1  stop bit sampled low on the last frame.
- break_det  output  1  high while a break condition is present.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - All outputs reset to 0. The synchronizer flops reset to 1 (idle).
  - On reset, the FSM goes to IDLE and all counters clear.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s, which adds 2 clk of latency.
- State register: state is 2 bits: IDLE, START, DATA, STOP.
  - Counter s_reg is 5 bits and counts ticks.
  - Counter n_reg is 4 bits and counts data bits.
  - Shift register b_reg is DBIT bits.
- IDLE:
  - On the falling edge of rx_s (previous value 1, current 0), go to START with s_reg = 0.
  - Ticks are ignored in IDLE.
- START: counts s_tick only.
  - At s_reg == OS/2-1, sample rx_s.
  - If rx_s is 0, go to DATA with s_reg = 0 and n_reg = 0.
  - If rx_s is 1, it was a glitch: return to IDLE with no strobe and no error.
- DATA:
  - At s_reg == OS-1, shift rx_s into the MSB of b_reg (right shift, so LSB-first data arrives at b_reg[0] at the end) and clear s_reg.
  - After sampling bit DBIT-1 (n_reg == DBIT-1), go to STOP.
- STOP:
  - At s_reg == SB_TICK-1, sample rx_s. Only the first stop-bit midpoint is checked; the remainder is just timed.
  - If rx_s is 1:
    - dout <= b_reg and frame_err <= 0.
    - Pulse rx_done_tick for one clk.
    - Go to IDLE.
  - If rx_s is 0 (framing error):
    - dout <= b_reg and frame_err <= 1.
    - Still pulse rx_done_tick for one clk.
    - If b_reg is all zeros, set break_det = 1.
    - Go to IDLE.
- break_det: clears on the first rx_s high in IDLE. No new frame starts until rx_s has returned high.
- Latency: rx_done_tick asserts 1 clk after the stop-sample tick.
- Ticks on consecutive clk cycles are legal, and each one counts.
- An rx_s change on the same clk as a tick is sampled after synchronization only; no bypass path.
- frame_err holds until the next rx_done_tick.
- dout holds its value between frames.
- Reset mid-frame: the partial byte is discarded with no strobe, and the FSM is in IDLE on the cycle after reset deasserts.
- Back-to-back frames (stop bit followed immediately by a start bit) must be received with no lost byte. This requires IDLE to be re-entered before the next falling edge.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rx_s at ticks mid-1, mid and mid+1, where mid is OS/2-1 for start and OS-1 for data and stop. The state transitions on the mid+1 tick, and the remaining tick counts are shortened by 1 so the total frame timing is unchanged.
- Undefined: single sample at mid. No extra flops are synthesized.

Test Plan:
1. Use DVSR=163, OS=16 and send 0x81 LSB first, stop bit high. Expect one rx_done_tick pulse, dout=0x81, frame_err=0.
2. Send 0x55 then 0xA3 back-to-back with no idle gap. Expect two strobes, dout 0x55 then 0xA3, no bytes lost.
3. Drive rx low for 3 ticks then high (a glitch). Expect the FSM back in IDLE, no strobe, and dout unchanged.
4. Send 0x3C with the stop bit forced low. Expect a strobe, dout=0x3C, frame_err=1, break_det=0. A good frame afterwards must clear frame_err.
5. Hold rx low for 2 full frames. Expect one strobe with dout=0x00, frame_err=1 and break_det=1; break_det clears once rx returns high and no second strobe occurs.
6. Assert reset during DATA bit 4 of 0xF0, then send 0x12. Expect no strobe for the aborted frame, outputs at 0 during reset, and dout=0x12 for the new frame.
